// File: rtl/ifetch_sched_pkg.sv
// Shared types for the instruction-fetch scheduler: FSM state encoding,
// the NOP word substituted for faulting fetches, and the fetch-buffer entry.
package ifetch_sched_pkg;

    localparam int XLEN_W = 32;

    // Word pushed in place of real data when translation faults (addi x0,x0,0).
    localparam logic [XLEN_W-1:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_XLATE  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_KILL   = 3'd3,
        ST_HALT   = 3'd4
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN_W-1:0] data;
        logic [XLEN_W-1:0] pc;
        logic              fault;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_sched.sv
// Credit-based instruction-fetch sequencer between the fetch buffer and the
// MMU / instruction-cache pair. One word in flight at a time; a redirect that
// lands while a cache read is outstanding drains that read and discards it.
// Optional perf counters are built when IFETCH_SCHED_PERF_EN is defined;
// otherwise perf_fetch_o / perf_kill_o are tied to zero.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for a free fetch-buffer credit
// XLATE  | translation request for fetch_pc outstanding
// ACCESS | cache read of paddr_q outstanding, response will be pushed
// KILL   | cache read outstanding for a flushed stream, response dropped
// HALT   | translation faulted, no requests until a redirect
import ifetch_sched_pkg::*;

module ifetch_sched #(
    parameter int              XLEN      = XLEN_W,
    parameter int              BUF_DEPTH = 2,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            pop_i,
    output logic            mmu_req_o,
    output logic [XLEN-1:0] mmu_vaddr_o,
    input  logic            mmu_hit_i,
    input  logic [XLEN-1:0] mmu_paddr_i,
    input  logic            mmu_fault_i,
    output logic            icache_req_o,
    output logic [XLEN-1:0] icache_addr_o,
    input  logic            icache_ack_i,
    input  logic [XLEN-1:0] icache_rdata_i,
    output logic            push_o,
    output logic [XLEN-1:0] push_data_o,
    output logic [XLEN-1:0] push_pc_o,
    output logic            push_fault_o,
    output logic [31:0]     perf_fetch_o,
    output logic [31:0]     perf_kill_o
);

    localparam int OCC_W = $clog2(BUF_DEPTH + 1);

    fetch_state_t     state, state_nxt;
    logic [XLEN-1:0]  fetch_pc, fetch_pc_nxt;
    logic [XLEN-1:0]  paddr_q, paddr_nxt;
    logic [XLEN-1:0]  pend_pc, pend_pc_nxt;
    logic [OCC_W-1:0] occ, occ_nxt, occ_avail;
    logic             push;
    logic             pop_ok;
    logic [XLEN-1:0]  redirect_pc;
    fetch_entry_t     entry;

    // Fetch is always word aligned; the low redirect bits are deliberately ignored.
    logic unused_redirect_bits;
    assign unused_redirect_bits = ^redirect_pc_i[1:0];
    assign redirect_pc = {redirect_pc_i[XLEN-1:2], 2'b00};

    // A pop against an empty buffer is a consumer glitch and is ignored.
    assign pop_ok    = pop_i && (occ != '0);
    assign occ_avail = pop_ok ? occ - OCC_W'(1) : occ;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            fetch_pc <= RESET_PC;
            paddr_q  <= '0;
            pend_pc  <= '0;
            occ      <= '0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            paddr_q  <= paddr_nxt;
            pend_pc  <= pend_pc_nxt;
            occ      <= occ_nxt;
        end
    end

    // Next-state logic and per-state request/push outputs.
    always_comb begin
        state_nxt     = state;
        fetch_pc_nxt  = fetch_pc;
        paddr_nxt     = paddr_q;
        pend_pc_nxt   = pend_pc;
        mmu_req_o     = 1'b0;
        mmu_vaddr_o   = '0;
        icache_req_o  = 1'b0;
        icache_addr_o = '0;
        push          = 1'b0;
        entry         = '0;

        unique case (state)
            ST_IDLE: begin
                if (occ_avail < OCC_W'(BUF_DEPTH)) state_nxt = ST_XLATE;
            end
            ST_XLATE: begin
                mmu_req_o   = 1'b1;
                mmu_vaddr_o = fetch_pc;
                if (mmu_hit_i) begin
                    paddr_nxt = mmu_paddr_i;
                    state_nxt = ST_ACCESS;
                end else if (mmu_fault_i) begin
                    push        = 1'b1;
                    entry.data  = INSTR_NOP;
                    entry.pc    = fetch_pc;
                    entry.fault = 1'b1;
                    state_nxt   = ST_HALT;
                end
            end
            ST_ACCESS: begin
                icache_req_o  = 1'b1;
                icache_addr_o = paddr_q;
                if (icache_ack_i) begin
                    push         = 1'b1;
                    entry.data   = icache_rdata_i;
                    entry.pc     = fetch_pc;
                    fetch_pc_nxt = fetch_pc + XLEN'(4);
                    state_nxt    = ST_IDLE;
                end
            end
            ST_KILL: begin
                icache_req_o  = 1'b1;
                icache_addr_o = paddr_q;
                if (icache_ack_i) begin
                    fetch_pc_nxt = pend_pc;
                    state_nxt    = ST_IDLE;
                end
            end
            ST_HALT: begin
                state_nxt = ST_HALT;
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Redirect overrides everything. If the cache read completes in the
        // same cycle there is nothing left to drain, so restart directly
        // instead of parking in KILL waiting for an ack that will not come.
        if (redirect_i) begin
            push  = 1'b0;
            entry = '0;
            if ((state == ST_ACCESS || state == ST_KILL) && !icache_ack_i) begin
                pend_pc_nxt = redirect_pc;
                state_nxt   = ST_KILL;
            end else begin
                fetch_pc_nxt = redirect_pc;
                state_nxt    = ST_IDLE;
            end
        end
    end

    // Buffer occupancy tracking (credit count).
    always_comb begin
        occ_nxt = occ;
        if (redirect_i)           occ_nxt = '0;
        else if (push && !pop_ok) occ_nxt = occ + OCC_W'(1);
        else if (!push && pop_ok) occ_nxt = occ - OCC_W'(1);
    end

    assign push_o       = push;
    assign push_data_o  = entry.data;
    assign push_pc_o    = entry.pc;
    assign push_fault_o = entry.fault;

`ifdef IFETCH_SCHED_PERF_EN
    logic [31:0] fetch_cnt, kill_cnt;
    logic        fetch_ev, kill_ev;

    assign fetch_ev = push && !entry.fault;
    assign kill_ev  = icache_ack_i &&
                      ((state == ST_KILL) || (state == ST_ACCESS && redirect_i));

    // Saturating event counters, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt <= '0;
            kill_cnt  <= '0;
        end else begin
            if (fetch_ev && fetch_cnt != 32'hFFFF_FFFF) fetch_cnt <= fetch_cnt + 32'd1;
            if (kill_ev && kill_cnt != 32'hFFFF_FFFF)   kill_cnt  <= kill_cnt + 32'd1;
        end
    end

    assign perf_fetch_o = fetch_cnt;
    assign perf_kill_o  = kill_cnt;
`else
    assign perf_fetch_o = '0;
    assign perf_kill_o  = '0;
`endif

endmodule

// File: tb/tb_ifetch_sched.sv
// Directed bench for ifetch_sched: reset, credit stall, pop resume, redirect
// into a live cache read, fault/halt, push+pop occupancy, PC wrap, mid-run reset.
`timescale 1ns/1ps
module tb_ifetch_sched;

`ifdef IFETCH_SCHED_PERF_EN
    localparam logic PERF_ON = 1'b1;
`else
    localparam logic PERF_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        pop = 1'b0;
    logic        mmu_req;
    logic [31:0] mmu_vaddr;
    logic        mmu_hit = 1'b0;
    logic [31:0] mmu_paddr = '0;
    logic        mmu_fault = 1'b0;
    logic        icache_req;
    logic [31:0] icache_addr;
    logic        icache_ack = 1'b0;
    logic [31:0] icache_rdata = '0;
    logic        push;
    logic [31:0] push_data;
    logic [31:0] push_pc;
    logic        push_fault;
    logic [31:0] perf_fetch;
    logic [31:0] perf_kill;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_fetch = 0;

    ifetch_sched dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_i     (redirect),
        .redirect_pc_i  (redirect_pc),
        .pop_i          (pop),
        .mmu_req_o      (mmu_req),
        .mmu_vaddr_o    (mmu_vaddr),
        .mmu_hit_i      (mmu_hit),
        .mmu_paddr_i    (mmu_paddr),
        .mmu_fault_i    (mmu_fault),
        .icache_req_o   (icache_req),
        .icache_addr_o  (icache_addr),
        .icache_ack_i   (icache_ack),
        .icache_rdata_i (icache_rdata),
        .push_o         (push),
        .push_data_o    (push_data),
        .push_pc_o      (push_pc),
        .push_fault_o   (push_fault),
        .perf_fetch_o   (perf_fetch),
        .perf_kill_o    (perf_kill)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!mmu_req && n < 20) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, mmu_req}, 32'd1);
    endtask

    task automatic expect_quiet(input int cycles, input string tag);
        logic seen = 1'b0;
        repeat (cycles) begin
            tick();
            seen = seen | mmu_req | icache_req | push;
        end
        chk(tag, {31'd0, seen}, 32'd0);
    endtask

    // One full translate + cache read, checking every handshake on the way.
    task automatic fetch_word(input logic [31:0] va, input logic [31:0] pa,
                              input logic [31:0] data, input int mlat,
                              input int clat, input logic pop_at_ack);
        wait_req("mmu_req_seen");
        chk("mmu_vaddr", mmu_vaddr, va);
        repeat (mlat) tick();
        mmu_hit = 1'b1;
        mmu_paddr = pa;
        #1;
        chk("xlate_no_push", {31'd0, push}, 32'd0);
        tick();
        mmu_hit = 1'b0;
        mmu_paddr = '0;
        #1;
        chk("icache_req", {31'd0, icache_req}, 32'd1);
        chk("icache_addr", icache_addr, pa);
        repeat (clat) tick();
        icache_ack = 1'b1;
        icache_rdata = data;
        pop = pop_at_ack;
        #1;
        chk("push", {31'd0, push}, 32'd1);
        chk("push_data", push_data, data);
        chk("push_pc", push_pc, va);
        chk("push_fault", {31'd0, push_fault}, 32'd0);
        exp_fetch++;
        tick();
        icache_ack = 1'b0;
        icache_rdata = '0;
        pop = 1'b0;
        #1;
        chk("push_clear", {31'd0, push}, 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mmu_req", {31'd0, mmu_req}, 32'd0);
        chk("rst_icache_req", {31'd0, icache_req}, 32'd0);
        chk("rst_push", {31'd0, push}, 32'd0);
        chk("rst_perf_fetch", perf_fetch, 32'd0);
        chk("rst_perf_kill", perf_kill, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("idle_after_rst", {31'd0, mmu_req}, 32'd0);
        tick();
        chk("first_req", {31'd0, mmu_req}, 32'd1);
        chk("first_vaddr", mmu_vaddr, 32'h8000_0000);

        // Fill the buffer, then requests must stop at occ=2
        fetch_word(32'h8000_0000, 32'h0000_1000, 32'h1111_0001, 1, 1, 1'b0);
        fetch_word(32'h8000_0004, 32'h0000_1004, 32'h1111_0002, 1, 1, 1'b0);
        expect_quiet(8, "full_stall");

        // One pop buys exactly one more fetch
        pop = 1'b1;
        tick();
        pop = 1'b0;
        fetch_word(32'h8000_0008, 32'h0000_1008, 32'h2222_0003, 0, 0, 1'b0);
        expect_quiet(8, "stall_after_pop");

        // Redirect while the cache read is outstanding
        pop = 1'b1;
        tick();
        pop = 1'b0;
        #1;
        chk("pre_kill_vaddr", mmu_vaddr, 32'h8000_000C);
        mmu_hit = 1'b1;
        mmu_paddr = 32'h0000_3000;
        tick();
        mmu_hit = 1'b0;
        mmu_paddr = '0;
        redirect = 1'b1;
        redirect_pc = 32'h8000_0102;
        #1;
        chk("access_req", {31'd0, icache_req}, 32'd1);
        chk("redirect_no_push", {31'd0, push}, 32'd0);
        tick();
        redirect = 1'b0;
        redirect_pc = '0;
        #1;
        chk("kill_req_held", {31'd0, icache_req}, 32'd1);
        chk("kill_addr", icache_addr, 32'h0000_3000);
        tick();
        tick();
        icache_ack = 1'b1;
        icache_rdata = 32'hDEAD_BEEF;
        #1;
        chk("kill_no_push", {31'd0, push}, 32'd0);
        tick();
        icache_ack = 1'b0;
        icache_rdata = '0;
        #1;
        chk("perf_kill", perf_kill, PERF_ON ? 32'd1 : 32'd0);
        chk("kill_to_idle", {31'd0, mmu_req}, 32'd0);

        // New stream from the aligned redirect PC; push+pop at occ=1 keeps occ=1
        fetch_word(32'h8000_0100, 32'h0000_4100, 32'h3333_0001, 0, 2, 1'b0);
        fetch_word(32'h8000_0104, 32'h0000_4104, 32'h3333_0002, 2, 0, 1'b1);
        fetch_word(32'h8000_0108, 32'h0000_4108, 32'h3333_0003, 0, 0, 1'b0);
        expect_quiet(8, "stall_occ2");

        // Redirect and pop together clear occ; request appears two cycles later
        redirect = 1'b1;
        redirect_pc = 32'h8000_2000;
        pop = 1'b1;
        tick();
        redirect = 1'b0;
        redirect_pc = '0;
        pop = 1'b0;
        #1;
        chk("redir_idle", {31'd0, mmu_req}, 32'd0);
        tick();
        chk("redir_req_n2", {31'd0, mmu_req}, 32'd1);
        fetch_word(32'h8000_2000, 32'h0000_5000, 32'h4444_0001, 0, 0, 1'b0);
        fetch_word(32'h8000_2004, 32'h0000_5004, 32'h4444_0002, 0, 0, 1'b0);
        expect_quiet(8, "stall_after_redir_pop");

        // Translation fault pushes a NOP marked faulty, then halts
        redirect = 1'b1;
        redirect_pc = 32'h8000_1000;
        tick();
        redirect = 1'b0;
        redirect_pc = '0;
        wait_req("fault_req_seen");
        chk("fault_vaddr", mmu_vaddr, 32'h8000_1000);
        mmu_fault = 1'b1;
        #1;
        chk("fault_push", {31'd0, push}, 32'd1);
        chk("fault_flag", {31'd0, push_fault}, 32'd1);
        chk("fault_data", push_data, 32'h0000_0013);
        chk("fault_pc", push_pc, 32'h8000_1000);
        tick();
        mmu_fault = 1'b0;
        expect_quiet(10, "halt_quiet");

        // PC wrap: low redirect bits dropped, next word at address 0
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        tick();
        redirect = 1'b0;
        redirect_pc = '0;
        fetch_word(32'hFFFF_FFFC, 32'h0000_6000, 32'h5555_0001, 0, 1, 1'b0);
        fetch_word(32'h0000_0000, 32'h0000_6004, 32'h5555_0002, 1, 0, 1'b0);
        chk("perf_fetch", perf_fetch, PERF_ON ? exp_fetch : 32'd0);

        // Reset while a cache read is outstanding; a late ack must be ignored
        redirect = 1'b1;
        redirect_pc = 32'h8000_4000;
        tick();
        redirect = 1'b0;
        redirect_pc = '0;
        wait_req("midrst_req_seen");
        mmu_hit = 1'b1;
        mmu_paddr = 32'h0000_7000;
        tick();
        mmu_hit = 1'b0;
        mmu_paddr = '0;
        #1;
        chk("midrst_access", {31'd0, icache_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_icache_clr", {31'd0, icache_req}, 32'd0);
        chk("midrst_perf_clr", perf_fetch, 32'd0);
        icache_ack = 1'b1;
        icache_rdata = 32'hBAD0_BAD0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("late_ack_no_push", {31'd0, push}, 32'd0);
        tick();
        icache_ack = 1'b0;
        chk("postrst_vaddr", mmu_vaddr, 32'h8000_0000);
        chk("postrst_no_push", {31'd0, push}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
